rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Scheduler for the register file's single write port (WE3/A3/WD3). It shares the port between the in-order writeback stage (primary) and long-latency units such as the multi-cycle multiplier (secondary). Secondary results are buffered in a 2-entry FIFO, and a starvation counter guarantees them forward progress. It keeps a per-register pending scoreboard for the hazard/stall logic and diverts writes addressed to R15 onto the PC write path, because the register file sources R15 externally.

## Interface
Parameters:
- DATA_W, 32, write data width
- ADDR_W, 4, register index width (16 registers)
- STARVE_MAX, 4, consecutive secondary losses before the secondary is forced to win (≥1)

Ports:
- CLK  in  1  single clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- P_VALID  in  1  primary writeback request
- P_A3  in  ADDR_W  primary destination index
- P_WD3  in  DATA_W  primary write data
- P_READY  out  1  primary request accepted this cycle (combinational)
- S_VALID  in  1  secondary result offered
- S_A3  in  ADDR_W  secondary destination index
- S_WD3  in  DATA_W  secondary write data
- S_READY  out  1  FIFO can accept (combinational, equals !full)
- ISSUE_VALID  in  1  a secondary op was issued this cycle
- ISSUE_A3  in  ADDR_W  destination of the issued op
- WE3  out  1  register file write enable (registered)
- A3  out  ADDR_W  register file write index (registered)
- WD3  out  DATA_W  register file write data (registered)
- PC_WE  out  1  PC write strobe for R15 destinations (registered)
- PC_WD  out  DATA_W  PC write data (registered)
- PENDING  out  2^ADDR_W  scoreboard bitmask, bit i set means register i awaits a secondary result (registered)

## Operation
- **FIFO:** 2 entries, each holding {A3, data}.
  - Push on S_VALID && S_READY.
  - Pop when the head is granted.
  - No push while full, even when a pop occurs in the same cycle.
  - No bypass: an entry pushed at edge E is eligible for grant from cycle E+1.
- **Arbitration:** evaluated every cycle, with two candidates: P_VALID and a non-empty FIFO head.
  - Default: primary wins, so P_READY = P_VALID-independent 1.
  - Starvation counter: increments on each cycle the FIFO is non-empty and the head is not granted. It clears when the head is granted or the FIFO is empty.
  - Override: when the counter equals STARVE_MAX, the secondary wins, P_READY = 0, and the counter clears at the next edge.
  - When the FIFO is non-empty and P_VALID = 0, the head is granted immediately.
- **Write issue:** the winner's {A3, data} is registered.
  - A3 ≠ 15 → WE3 = 1, A3, WD3 driven, PC_WE = 0.
  - A3 = 15 → WE3 = 0, PC_WE = 1, PC_WD = data; A3/WD3 hold their previous values.
  - No winner → WE3 = 0, PC_WE = 0.
- **Scoreboard:**
  - ISSUE_VALID sets PENDING[ISSUE_A3].
  - A granted secondary write clears PENDING[its A3].
  - Same index set and cleared in the same cycle → the bit ends set (new issue wins).
  - Issue to an already-pending index → the bit stays set. Upstream stall logic prevents this; the block does not flag it.
  - Primary writes never touch PENDING and are never blocked by it.
- **Reset (RESET_N low, asynchronous):**
  - Registered state: FIFO empty, counter 0, WE3 = 0, A3 = 0, WD3 = 0, PC_WE = 0, PC_WD = 0, PENDING = 0.
  - Combinational outputs while reset is held: P_READY = 0 and S_READY = 0.
  - Reset mid-operation discards buffered entries and pending bits.

## Timing
- Grant decided in cycle N. WE3/A3/WD3 (or PC_WE/PC_WD) are valid throughout cycle N+1, and the register file captures at the edge ending N+1. Latency is 1 cycle for both requesters.
- Secondary minimum latency: S_VALID at cycle N → push at the end of N → grant in N+1 → WE3 in N+2.
- PENDING bits change at the grant edge, so a clear is visible in the same cycle WE3 is high.
- Maximum secondary wait with a saturated primary: STARVE_MAX + 1 cycles from becoming head.
- Back-to-back grants are allowed every cycle. WE3 may stay high for consecutive cycles with different A3.
- Release of RESET_N is synchronised externally. The first grant can occur in the first cycle after release.

## Test plan
- **Reset check:** assert RESET_N low mid-stream with 2 FIFO entries and PENDING = 16'h0006 → all outputs 0 immediately. After release, S_READY = 1 and PENDING = 0.
- **Primary only:** P_VALID with A3 = 1..14 and WD3 = A3 on consecutive cycles → WE3 = 1 each following cycle with matching A3/WD3. P_READY is constantly 1.
- **Starvation:** P_VALID held high, one secondary push (A3 = 5, data 32'hDEAD) with STARVE_MAX = 4 → 4 primary grants, then P_READY = 0 for one cycle, then WE3 with A3 = 5, WD3 = 32'hDEAD. PENDING[5] clears on that edge.
- **FIFO full:** three S_VALID pushes while P_VALID = 1 → S_READY = 0 after 2 pushes, and the third is held until a pop. Data order is preserved.
- **R15 divert:** primary write A3 = 15, data 32'h100 → PC_WE = 1, PC_WD = 32'h100, WE3 = 0. The same holds for a secondary R15 write, which also clears PENDING[15].
- **Scoreboard collision:** ISSUE_A3 = 3 in the same cycle a secondary write to register 3 is granted → PENDING[3] remains 1. WE3 writes register 3.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file write port between writeback and a buffered secondary source
module rf_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     P_VALID,
    input  logic [ADDR_W-1:0]        P_A3,
    input  logic [DATA_W-1:0]        P_WD3,
    output logic                     P_READY,
    input  logic                     S_VALID,
    input  logic [ADDR_W-1:0]        S_A3,
    input  logic [DATA_W-1:0]        S_WD3,
    output logic                     S_READY,
    input  logic                     ISSUE_VALID,
    input  logic [ADDR_W-1:0]        ISSUE_A3,
    output logic                     WE3,
    output logic [ADDR_W-1:0]        A3,
    output logic [DATA_W-1:0]        WD3,
    output logic                     PC_WE,
    output logic [DATA_W-1:0]        PC_WD,
    output logic [(1<<ADDR_W)-1:0]   PENDING
);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam int NR = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_IDX = '1;

    logic [ADDR_W-1:0] fifo_a [2];
    logic [DATA_W-1:0] fifo_d [2];
    logic              rd_ptr, wr_ptr;
    logic [1:0]        count;
    logic [CW-1:0]     starve, starve_nxt;
    logic              head_v, full, force_s, grant_s, grant_p, win_v, push;
    logic [ADDR_W-1:0] win_a;
    logic [DATA_W-1:0] win_d;
    logic [NR-1:0]     pending_nxt;

    // arbitration: primary wins unless the buffered head has starved long enough or primary is idle
    always_comb begin
        head_v      = count != 2'd0;
        full        = count == 2'd2;
        force_s     = head_v && starve == CW'(STARVE_MAX);
        grant_s     = head_v && (force_s || !P_VALID);
        grant_p     = P_VALID && !force_s;
        win_v       = grant_s || grant_p;
        win_a       = grant_s ? fifo_a[rd_ptr] : P_A3;
        win_d       = grant_s ? fifo_d[rd_ptr] : P_WD3;
        push        = S_VALID && !full;
        P_READY     = RESET_N && !force_s;
        S_READY     = RESET_N && !full;
        starve_nxt  = (head_v && !grant_s) ? starve + 1'b1 : '0;
        pending_nxt = PENDING;
        if (grant_s) pending_nxt[fifo_a[rd_ptr]] = 1'b0;
        if (ISSUE_VALID) pending_nxt[ISSUE_A3] = 1'b1;
    end

    // FIFO payload storage; contents are don't-care while empty
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_a[wr_ptr] <= S_A3;
            fifo_d[wr_ptr] <= S_WD3;
        end
    end

    // FIFO pointers, occupancy, starvation counter and scoreboard
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
            starve  <= '0;
            PENDING <= '0;
        end else begin
            if (push) wr_ptr <= !wr_ptr;
            if (grant_s) rd_ptr <= !rd_ptr;
            count   <= count + {1'b0, push} - {1'b0, grant_s};
            starve  <= starve_nxt;
            PENDING <= pending_nxt;
        end
    end

    // register the winner; R15 goes to the PC path and leaves A3/WD3 untouched
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            WE3   <= 1'b0;
            A3    <= '0;
            WD3   <= '0;
            PC_WE <= 1'b0;
            PC_WD <= '0;
        end else begin
            WE3   <= win_v && win_a != PC_IDX;
            PC_WE <= win_v && win_a == PC_IDX;
            if (win_v && win_a != PC_IDX) begin
                A3  <= win_a;
                WD3 <= win_d;
            end
            if (win_v && win_a == PC_IDX) PC_WD <= win_d;
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scenario tests for the register file write arbiter
module tb_rf_write_arbiter;
    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        P_VALID, S_VALID, ISSUE_VALID;
    logic [3:0]  P_A3, S_A3, ISSUE_A3;
    logic [31:0] P_WD3, S_WD3;
    logic        P_READY, S_READY, WE3, PC_WE;
    logic [3:0]  A3;
    logic [31:0] WD3, PC_WD;
    logic [15:0] PENDING;
    int checks = 0;
    int failures = 0;

    rf_write_arbiter #(.DATA_W(32), .ADDR_W(4), .STARVE_MAX(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .P_VALID(P_VALID), .P_A3(P_A3), .P_WD3(P_WD3), .P_READY(P_READY),
        .S_VALID(S_VALID), .S_A3(S_A3), .S_WD3(S_WD3), .S_READY(S_READY),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_A3(ISSUE_A3),
        .WE3(WE3), .A3(A3), .WD3(WD3), .PC_WE(PC_WE), .PC_WD(PC_WD), .PENDING(PENDING)
    );

    always #5 CLK = !CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (P_READY !== 1'b0) begin failures++; $display("FAIL rst_p_ready got=%0b exp=0", P_READY); end
        checks++; if (S_READY !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%0b exp=0", S_READY); end
        checks++; if ({WE3, PC_WE, A3, WD3, PC_WD, PENDING} !== '0) begin failures++; $display("FAIL rst_regs we3=%0b pc_we=%0b a3=%0d wd3=%h pc_wd=%h pending=%h exp all 0", WE3, PC_WE, A3, WD3, PC_WD, PENDING); end
        step; step;
        RESET_N = 1'b1;
        #1;
        checks++; if (S_READY !== 1'b1) begin failures++; $display("FAIL rel_s_ready got=%0b exp=1", S_READY); end
        checks++; if (P_READY !== 1'b1) begin failures++; $display("FAIL rel_p_ready got=%0b exp=1", P_READY); end
        step;
        checks++; if (WE3 !== 1'b0 || PC_WE !== 1'b0) begin failures++; $display("FAIL rel_idle we3=%0b pc_we=%0b exp=0/0", WE3, PC_WE); end
    endtask

    task automatic test_primary;
        for (int i = 1; i <= 14; i++) begin
            P_VALID = 1'b1; P_A3 = 4'(i); P_WD3 = 32'(i);
            #1;
            checks++; if (P_READY !== 1'b1) begin failures++; $display("FAIL prim_ready i=%0d got=%0b exp=1", i, P_READY); end
            step;
            checks++; if (WE3 !== 1'b1 || A3 !== 4'(i) || WD3 !== 32'(i) || PC_WE !== 1'b0) begin failures++; $display("FAIL prim_write i=%0d we3=%0b a3=%0d wd3=%h pc_we=%0b exp we3=1 a3=%0d wd3=%h pc_we=0", i, WE3, A3, WD3, PC_WE, i, i); end
        end
        P_VALID = 1'b0;
        step;
        checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL prim_idle we3=%0b exp=0", WE3); end
    endtask

    task automatic test_starvation;
        P_VALID = 1'b1; P_A3 = 4'd1; P_WD3 = 32'h1;
        S_VALID = 1'b1; S_A3 = 4'd5; S_WD3 = 32'hDEAD;
        ISSUE_VALID = 1'b1; ISSUE_A3 = 4'd5;
        step;
        S_VALID = 1'b0; ISSUE_VALID = 1'b0;
        checks++; if (PENDING !== 16'h0020) begin failures++; $display("FAIL starve_pend_set got=%h exp=0020", PENDING); end
        checks++; if (WE3 !== 1'b1 || A3 !== 4'd1) begin failures++; $display("FAIL starve_first we3=%0b a3=%0d exp 1/1", WE3, A3); end
        for (int k = 0; k < 4; k++) begin
            P_A3 = 4'(k + 2); P_WD3 = 32'(k + 2);
            #1;
            checks++; if (P_READY !== 1'b1) begin failures++; $display("FAIL starve_ready k=%0d got=%0b exp=1", k, P_READY); end
            step;
            checks++; if (WE3 !== 1'b1 || A3 !== 4'(k + 2) || WD3 !== 32'(k + 2)) begin failures++; $display("FAIL starve_prim k=%0d we3=%0b a3=%0d wd3=%h exp a3=%0d", k, WE3, A3, WD3, k + 2); end
        end
        P_A3 = 4'd9; P_WD3 = 32'h9;
        #1;
        checks++; if (P_READY !== 1'b0) begin failures++; $display("FAIL starve_force_ready got=%0b exp=0", P_READY); end
        step;
        checks++; if (WE3 !== 1'b1 || A3 !== 4'd5 || WD3 !== 32'hDEAD) begin failures++; $display("FAIL starve_sec we3=%0b a3=%0d wd3=%h exp 1/5/0000dead", WE3, A3, WD3); end
        checks++; if (PENDING !== 16'h0000) begin failures++; $display("FAIL starve_pend_clr got=%h exp=0000", PENDING); end
        checks++; if (P_READY !== 1'b1) begin failures++; $display("FAIL starve_after_ready got=%0b exp=1", P_READY); end
        step;
        checks++; if (WE3 !== 1'b1 || A3 !== 4'd9 || WD3 !== 32'h9) begin failures++; $display("FAIL starve_after we3=%0b a3=%0d wd3=%h exp 1/9/9", WE3, A3, WD3); end
        P_VALID = 1'b0;
        step;
    endtask

    task automatic test_fifo_full;
        P_VALID = 1'b1; P_A3 = 4'd1; P_WD3 = 32'h1;
        S_VALID = 1'b1; S_A3 = 4'd6; S_WD3 = 32'h66;
        #1;
        checks++; if (S_READY !== 1'b1) begin failures++; $display("FAIL full_rdy0 got=%0b exp=1", S_READY); end
        step;
        S_A3 = 4'd7; S_WD3 = 32'h77;
        #1;
        checks++; if (S_READY !== 1'b1) begin failures++; $display("FAIL full_rdy1 got=%0b exp=1", S_READY); end
        step;
        S_A3 = 4'd8; S_WD3 = 32'h88;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (S_READY !== 1'b0 || P_READY !== 1'b1) begin failures++; $display("FAIL full_hold k=%0d s_ready=%0b p_ready=%0b exp 0/1", k, S_READY, P_READY); end
            step;
        end
        #1;
        checks++; if (S_READY !== 1'b0 || P_READY !== 1'b0) begin failures++; $display("FAIL full_force s_ready=%0b p_ready=%0b exp 0/0", S_READY, P_READY); end
        step;
        checks++; if (WE3 !== 1'b1 || A3 !== 4'd6 || WD3 !== 32'h66) begin failures++; $display("FAIL full_pop0 we3=%0b a3=%0d wd3=%h exp 1/6/66", WE3, A3, WD3); end
        #1;
        checks++; if (S_READY !== 1'b1) begin failures++; $display("FAIL full_reopen got=%0b exp=1", S_READY); end
        step;
        S_VALID = 1'b0; P_VALID = 1'b0;
        checks++; if (WE3 !== 1'b1 || A3 !== 4'd1) begin failures++; $display("FAIL full_prim we3=%0b a3=%0d exp 1/1", WE3, A3); end
        step;
        checks++; if (WE3 !== 1'b1 || A3 !== 4'd7 || WD3 !== 32'h77) begin failures++; $display("FAIL full_pop1 we3=%0b a3=%0d wd3=%h exp 1/7/77", WE3, A3, WD3); end
        step;
        checks++; if (WE3 !== 1'b1 || A3 !== 4'd8 || WD3 !== 32'h88) begin failures++; $display("FAIL full_pop2 we3=%0b a3=%0d wd3=%h exp 1/8/88", WE3, A3, WD3); end
        step;
        checks++; if (WE3 !== 1'b0) begin failures++; $display("FAIL full_empty we3=%0b exp=0", WE3); end
    endtask

    task automatic test_r15;
        P_VALID = 1'b1; P_A3 = 4'd15; P_WD3 = 32'h100;
        step;
        P_VALID = 1'b0;
        checks++; if (PC_WE !== 1'b1 || PC_WD !== 32'h100 || WE3 !== 1'b0) begin failures++; $display("FAIL r15_prim pc_we=%0b pc_wd=%h we3=%0b exp 1/100/0", PC_WE, PC_WD, WE3); end
        checks++; if (A3 !== 4'd8 || WD3 !== 32'h88) begin failures++; $display("FAIL r15_hold a3=%0d wd3=%h exp 8/88", A3, WD3); end
        ISSUE_VALID = 1'b1; ISSUE_A3 = 4'd15;
        S_VALID = 1'b1; S_A3 = 4'd15; S_WD3 = 32'h200;
        step;
        ISSUE_VALID = 1'b0; S_VALID = 1'b0;
        checks++; if (PC_WE !== 1'b0 || WE3 !== 1'b0) begin failures++; $display("FAIL r15_gap pc_we=%0b we3=%0b exp 0/0", PC_WE, WE3); end
        checks++; if (PENDING !== 16'h8000) begin failures++; $display("FAIL r15_pend_set got=%h exp=8000", PENDING); end
        step;
        checks++; if (PC_WE !== 1'b1 || PC_WD !== 32'h200 || WE3 !== 1'b0) begin failures++; $display("FAIL r15_sec pc_we=%0b pc_wd=%h we3=%0b exp 1/200/0", PC_WE, PC_WD, WE3); end
        checks++; if (PENDING !== 16'h0000) begin failures++; $display("FAIL r15_pend_clr got=%h exp=0000", PENDING); end
        step;
        checks++; if (PC_WE !== 1'b0) begin failures++; $display("FAIL r15_idle pc_we=%0b exp=0", PC_WE); end
    endtask

    task automatic test_collision;
        ISSUE_VALID = 1'b1; ISSUE_A3 = 4'd3;
        S_VALID = 1'b1; S_A3 = 4'd3; S_WD3 = 32'h333;
        step;
        S_VALID = 1'b0;
        checks++; if (PENDING !== 16'h0008) begin failures++; $display("FAIL coll_set got=%h exp=0008", PENDING); end
        step;
        ISSUE_VALID = 1'b0;
        checks++; if (WE3 !== 1'b1 || A3 !== 4'd3 || WD3 !== 32'h333) begin failures++; $display("FAIL coll_write we3=%0b a3=%0d wd3=%h exp 1/3/333", WE3, A3, WD3); end
        checks++; if (PENDING !== 16'h0008) begin failures++; $display("FAIL coll_keep got=%h exp=0008", PENDING); end
        S_VALID = 1'b1; S_A3 = 4'd3; S_WD3 = 32'h444;
        step;
        S_VALID = 1'b0;
        step;
        checks++; if (WE3 !== 1'b1 || A3 !== 4'd3 || WD3 !== 32'h444 || PENDING !== 16'h0000) begin failures++; $display("FAIL coll_clear we3=%0b a3=%0d wd3=%h pending=%h exp 1/3/444/0000", WE3, A3, WD3, PENDING); end
    endtask

    task automatic test_reset_mid;
        P_VALID = 1'b1; P_A3 = 4'd2; P_WD3 = 32'h22;
        ISSUE_VALID = 1'b1; ISSUE_A3 = 4'd1;
        S_VALID = 1'b1; S_A3 = 4'd1; S_WD3 = 32'h11;
        step;
        ISSUE_A3 = 4'd2; S_A3 = 4'd2; S_WD3 = 32'h22;
        step;
        ISSUE_VALID = 1'b0; S_VALID = 1'b0;
        checks++; if (PENDING !== 16'h0006 || S_READY !== 1'b0) begin failures++; $display("FAIL mid_setup pending=%h s_ready=%0b exp 0006/0", PENDING, S_READY); end
        #2;
        RESET_N = 1'b0;
        #1;
        checks++; if ({WE3, PC_WE, A3, WD3, PC_WD, PENDING} !== '0) begin failures++; $display("FAIL mid_rst_regs we3=%0b pc_we=%0b a3=%0d wd3=%h pc_wd=%h pending=%h exp all 0", WE3, PC_WE, A3, WD3, PC_WD, PENDING); end
        checks++; if (P_READY !== 1'b0 || S_READY !== 1'b0) begin failures++; $display("FAIL mid_rst_ready p=%0b s=%0b exp 0/0", P_READY, S_READY); end
        P_VALID = 1'b0;
        step;
        RESET_N = 1'b1;
        #1;
        checks++; if (S_READY !== 1'b1 || P_READY !== 1'b1 || PENDING !== 16'h0000) begin failures++; $display("FAIL mid_release s=%0b p=%0b pending=%h exp 1/1/0000", S_READY, P_READY, PENDING); end
        step;
        checks++; if (WE3 !== 1'b0 || PC_WE !== 1'b0) begin failures++; $display("FAIL mid_discard we3=%0b pc_we=%0b exp 0/0", WE3, PC_WE); end
    endtask

    initial begin
        RESET_N = 1'b1;
        P_VALID = 1'b0; P_A3 = '0; P_WD3 = '0;
        S_VALID = 1'b0; S_A3 = '0; S_WD3 = '0;
        ISSUE_VALID = 1'b0; ISSUE_A3 = '0;
        #1 RESET_N = 1'b0;
        test_reset;
        test_primary;
        test_starvation;
        test_fifo_full;
        test_r15;
        test_collision;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
